// File: rtl/decoder_2_4_hold.sv
// rtl/decoder_2_4_hold.sv - registered 2-to-4 decoder with programmable hold and invalid-code accounting
//
// Receive-side partner of the 4-to-2 priority encoder. A code accepted through
// the valid/ready handshake drives a one-hot d_out for HOLD_CYCLES cycles, then
// d_out returns to zero. Codes flagged invalid by the encoder are dropped,
// counted (saturating) and latched into a sticky flag.
//
// Parameters:
//   HOLD_CYCLES  cycles d_out stays asserted per accepted code (1..255)
//   ERR_W        width of the invalid-code counter (>=1)
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   en           enable, gates acceptance only
//   in_valid     in_code/in_invalid presented
//   in_ready     decoder can accept (IDLE and enabled)
//   in_code      2-bit code to decode
//   in_invalid   encoder flagged the code as invalid
//   clr_err      synchronous clear of err_count/err_flag
//   d_out        one-hot decoded output
//   out_valid    d_out holds a decoded code
//   err_count    saturating count of accepted invalid codes
//   err_flag     sticky invalid-code indicator

module decoder_2_4_hold #(
  parameter int HOLD_CYCLES = 1,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_code,
  input  logic             in_invalid,
  input  logic             clr_err,
  output logic [3:0]       d_out,
  output logic             out_valid,
  output logic [ERR_W-1:0] err_count,
  output logic             err_flag
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // The counter is loaded with HOLD_CYCLES-1 so that the accept cycle itself
  // counts as the first of the HOLD_CYCLES output cycles.
  localparam logic [7:0]       HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;
  localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);

  logic [0:0] state;
  logic [7:0] hold_cnt;
  logic       accept;

  assign in_ready = (state == ST_IDLE) && en;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      hold_cnt  <= 8'd0;
      d_out     <= 4'b0000;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && !in_invalid) begin
            d_out     <= 4'b0001 << in_code;
            out_valid <= 1'b1;
            hold_cnt  <= HOLD_LOAD;
            state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (hold_cnt != 8'd0) begin
            hold_cnt <= hold_cnt - 8'd1;
          end else begin
            d_out     <= 4'b0000;
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          d_out     <= 4'b0000;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Accept can only happen in IDLE, so this needs no state qualification.
  // A clear coincident with a new invalid code keeps the new event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
      err_flag  <= 1'b0;
    end else if (accept && in_invalid) begin
      if (clr_err) begin
        err_count <= ERR_ONE;
      end else if (err_count != ERR_MAX) begin
        err_count <= err_count + ERR_ONE;
      end
      err_flag <= 1'b1;
    end else if (clr_err) begin
      err_count <= '0;
      err_flag  <= 1'b0;
    end
  end

endmodule

// File: doc/decoder_2_4_hold.md
# decoder_2_4_hold

Registered 2-to-4 line decoder and the receive-side counterpart of the 4-to-2 priority encoder. It accepts a 2-bit code plus the encoder's invalid-input flag through a valid/ready handshake. For each valid code it drives a one-hot 4-bit output for a programmable number of cycles, then returns to all-zero. Invalid codes are dropped, counted and flagged.

## Interface
- HOLD_CYCLES, 1: cycles the one-hot output stays asserted per accepted code; legal range 1..255.
- ERR_W, 8: width of the invalid-code counter; legal range ≥1.
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- en  input  1  decoder enable; gates acceptance only.
- in_valid  input  1  in_code/in_invalid are presented.
- in_ready  output  1  decoder can accept; combinational, equals (state==IDLE) && en.
- in_code  input  2  binary code to decode.
- in_invalid  input  1  encoder flagged the code as invalid.
- clr_err  input  1  synchronous clear of err_count/err_flag.
- d_out  output  4  one-hot decoded output, registered.
- out_valid  output  1  d_out holds a decoded code, registered.
- err_count  output  ERR_W  saturating count of accepted invalid codes.
- err_flag  output  1  sticky: at least one invalid code accepted since reset/clear.

## Operation
- Accept event: in_valid && in_ready sampled at a rising edge.
- States: IDLE, HOLD. The hold counter is 8 bits.
- IDLE, accept with in_invalid=0:
  - d_out <= 4'b0001 << in_code
  - out_valid <= 1
  - hold counter <= HOLD_CYCLES-1
  - go to HOLD
- IDLE, accept with in_invalid=1:
  - d_out and out_valid unchanged (remain 0)
  - err_count increments, saturating at 2^ERR_W-1
  - err_flag <= 1
  - stay in IDLE
- IDLE, no accept: no change.
- HOLD, hold counter ≠ 0: decrement.
- HOLD, hold counter = 0: d_out <= 0, out_valid <= 0, go to IDLE.
- In HOLD, in_ready=0; in_code is ignored.
- en=0: in_ready=0, so no accepts. A HOLD already in progress completes normally.
- clr_err=1 without an accept of an invalid code: err_count <= 0, err_flag <= 0.
- clr_err=1 coincident with an accept of an invalid code: the new event wins; err_count <= 1, err_flag <= 1.
- At saturation, further invalid codes leave err_count at max; err_flag stays 1.
- Only one d_out bit is ever high. d_out is non-zero iff out_valid=1.

## Timing
- Reset values (immediate on rst rise, independent of clk):
  - state IDLE
  - d_out 4'b0000
  - out_valid 0
  - err_count 0
  - err_flag 0
  - in_ready = en
- Latency: a code accepted at edge k appears on d_out after edge k. It stays for exactly HOLD_CYCLES cycles and clears after edge k+HOLD_CYCLES.
- in_ready rises after edge k+HOLD_CYCLES. The earliest next accept is edge k+HOLD_CYCLES+1, so sustained throughput is one code per HOLD_CYCLES+1 cycles.
- An invalid code does not leave IDLE. Invalid codes can be accepted back-to-back, one per cycle.
- err_count/err_flag update one edge after the accept.
- rst asserted mid-HOLD clears d_out and out_valid at once. The pending code is lost and is not replayed after reset.
- rst deasserted: the first accept is possible at the first rising edge with rst low.

## Test plan
- Reset: assert rst with en=1. Required: d_out=0000, out_valid=0, err_count=0, err_flag=0, in_ready=1. Then assert rst asynchronously between edges during HOLD. Required: d_out drops to 0000 before the next edge.
- HOLD_CYCLES=1, en=1, in_valid held high, codes 0,1,2,3 with in_invalid=0. Required: d_out sequence 0001,0010,0100,1000, each high 1 cycle and separated by one 0000 cycle; in_ready toggles 1/0.
- HOLD_CYCLES=3, code 2 accepted at edge 10. Required:
  - d_out=0100 and out_valid=1 after edges 10, 11, 12
  - 0000 after edge 13
  - in_ready=0 from edge 10 until after edge 13
  - a new code presented at edge 11 is not taken
- Invalid handling with ERR_W=2: 5 consecutive accepts with in_invalid=1. Required: d_out stays 0000, err_count goes 1,2,3,3,3, err_flag=1. Then clr_err alone: count 0, flag 0.
- clr_err coincident with an invalid accept. Required: err_count=1, err_flag=1.
- en=0 with in_valid=1. Required: in_ready=0 and no output. Dropping en during HOLD: the hold completes its full HOLD_CYCLES.
